// File: rtl/tactile_pkg.sv
// rtl/tactile_pkg.sv - shared types and constants for the tactile array scanner
package tactile_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_EMIT,
        ST_ADVANCE
    } scan_state_t;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int PIX_W    = 16;

    localparam logic [PIX_W-1:0] TIMEOUT_PIXEL = 16'hFFFF;

endpackage

// File: rtl/tactile_scanner_if.sv
// rtl/tactile_scanner_if.sv - scanner control, ADC handshake and pixel stream bundle
interface tactile_scanner_if #(
    parameter int SW_SEL_W  = 4,
    parameter int RD_SEL_W  = 4,
    parameter int ADC_WIDTH = 12
) ();
    import tactile_pkg::*;

    logic                 start_in;
    logic                 continuous_in;
    logic [ADC_WIDTH-1:0] adc_data_in;
    logic                 adc_valid_in;
    logic [SW_SEL_W-1:0]  sw_sel_out;
    logic                 sw_en_out;
    logic [RD_SEL_W-1:0]  rd_sel_out;
    logic                 adc_req_out;
    logic [PIX_W-1:0]     data_out;
    logic [HCOUNT_W-1:0]  hcount_out;
    logic [VCOUNT_W-1:0]  vcount_out;
    logic                 data_valid_out;
    logic                 busy_out;
    logic                 frame_done_out;
    logic                 timeout_err_out;

    modport master (
        input  start_in, continuous_in, adc_data_in, adc_valid_in,
        output sw_sel_out, sw_en_out, rd_sel_out, adc_req_out,
        output data_out, hcount_out, vcount_out, data_valid_out,
        output busy_out, frame_done_out, timeout_err_out
    );

    modport slave (
        output start_in, continuous_in, adc_data_in, adc_valid_in,
        input  sw_sel_out, sw_en_out, rd_sel_out, adc_req_out,
        input  data_out, hcount_out, vcount_out, data_valid_out,
        input  busy_out, frame_done_out, timeout_err_out
    );

endinterface

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter, expire_out high while the count reads 1
module settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] value_in,
    output logic             expire_out
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = value_in;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_out = (count_q == CNT_W'(1));

endmodule

// File: rtl/tactile_scanner.sv
// rtl/tactile_scanner.sv - raster scan of the tactile array: settle, convert, emit one pixel per crossing
module tactile_scanner
    import tactile_pkg::*;
#(
    parameter int SW_WIRE_CNT        = 16,
    parameter int RD_WIRE_CNT        = 16,
    parameter int ADC_WIDTH          = 12,
    parameter int SW_SETTLE_CYCLES   = 200,
    parameter int RD_SETTLE_CYCLES   = 20,
    parameter int ADC_TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    tactile_scanner_if.master  bus
);

    localparam int SW_SEL_W  = $clog2(SW_WIRE_CNT);
    localparam int RD_SEL_W  = $clog2(RD_WIRE_CNT);
    localparam int SET_MAX   = (SW_SETTLE_CYCLES > RD_SETTLE_CYCLES) ? SW_SETTLE_CYCLES : RD_SETTLE_CYCLES;
    localparam int SET_W     = $clog2(SET_MAX + 1);
    localparam int TO_W      = $clog2(ADC_TIMEOUT_CYCLES + 1);
    localparam logic [SW_SEL_W-1:0] SW_LAST = SW_SEL_W'(SW_WIRE_CNT - 1);
    localparam logic [RD_SEL_W-1:0] RD_LAST = RD_SEL_W'(RD_WIRE_CNT - 1);

    scan_state_t          state_q, state_d;
    logic [SW_SEL_W-1:0]  sw_sel_q, sw_sel_d;
    logic [RD_SEL_W-1:0]  rd_sel_q, rd_sel_d;
    logic                 sw_en_q, sw_en_d;
    logic                 busy_q, busy_d;
    logic                 adc_req_q, adc_req_d;
    logic [PIX_W-1:0]     data_q, data_d;
    logic [HCOUNT_W-1:0]  hcount_q, hcount_d;
    logic [VCOUNT_W-1:0]  vcount_q, vcount_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_q, err_d;

    logic                 set_load, set_expire, to_expire;
    logic [SET_W-1:0]     set_value;
    logic [ADC_WIDTH-1:0] adc_data;
    logic                 last_pix;

    assign adc_data = bus.adc_data_in;
    assign last_pix = (rd_sel_q == RD_LAST) && (sw_sel_q == SW_LAST);

    settle_timer #(.CNT_W(SET_W)) u_settle (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load_in    (set_load),
        .value_in   (set_value),
        .expire_out (set_expire)
    );

    // The timeout counter is loaded together with the request, so the request cycle counts as cycle 1.
    settle_timer #(.CNT_W(TO_W)) u_timeout (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load_in    (adc_req_d),
        .value_in   (TO_W'(ADC_TIMEOUT_CYCLES)),
        .expire_out (to_expire)
    );

    always_comb begin
        state_d      = state_q;
        sw_sel_d     = sw_sel_q;
        rd_sel_d     = rd_sel_q;
        sw_en_d      = sw_en_q;
        busy_d       = busy_q;
        adc_req_d    = 1'b0;
        data_d       = data_q;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        set_load     = 1'b0;
        set_value    = SET_W'(SW_SETTLE_CYCLES);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    sw_sel_d = '0;
                    rd_sel_d = '0;
                    sw_en_d  = 1'b1;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    set_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (set_expire) begin
                    adc_req_d = 1'b1;
                    state_d   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (bus.adc_valid_in || to_expire) begin
                    data_d       = bus.adc_valid_in ? PIX_W'(adc_data) : TIMEOUT_PIXEL;
                    err_d        = err_q | ~bus.adc_valid_in;
                    hcount_d     = HCOUNT_W'(rd_sel_q);
                    vcount_d     = VCOUNT_W'(sw_sel_q);
                    data_valid_d = 1'b1;
                    state_d      = ST_EMIT;
                end
            end
            ST_EMIT: begin
                frame_done_d = last_pix;
                state_d      = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                set_load = 1'b1;
                state_d  = ST_SETTLE;
                if (rd_sel_q != RD_LAST) begin
                    rd_sel_d  = rd_sel_q + 1'b1;
                    set_value = SET_W'(RD_SETTLE_CYCLES);
                end else begin
                    rd_sel_d = '0;
                    if (sw_sel_q != SW_LAST) begin
                        sw_sel_d = sw_sel_q + 1'b1;
                    end else if (bus.continuous_in) begin
                        sw_sel_d = '0;
                        err_d    = 1'b0;
                    end else begin
                        sw_sel_d = '0;
                        sw_en_d  = 1'b0;
                        busy_d   = 1'b0;
                        set_load = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            sw_sel_q     <= '0;
            rd_sel_q     <= '0;
            sw_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            adc_req_q    <= 1'b0;
            data_q       <= '0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sw_sel_q     <= sw_sel_d;
            rd_sel_q     <= rd_sel_d;
            sw_en_q      <= sw_en_d;
            busy_q       <= busy_d;
            adc_req_q    <= adc_req_d;
            data_q       <= data_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.sw_sel_out      = sw_sel_q;
    assign bus.sw_en_out       = sw_en_q;
    assign bus.rd_sel_out      = rd_sel_q;
    assign bus.adc_req_out     = adc_req_q;
    assign bus.data_out        = data_q;
    assign bus.hcount_out      = hcount_q;
    assign bus.vcount_out      = vcount_q;
    assign bus.data_valid_out  = data_valid_q;
    assign bus.busy_out        = busy_q;
    assign bus.frame_done_out  = frame_done_q;
    assign bus.timeout_err_out = err_q;

endmodule

// File: tb/tb_tactile_scanner.sv
// tb/tb_tactile_scanner.sv - randomized self-checking bench for tactile_scanner against a cycle-event model
module tb_tactile_scanner;
    import tactile_pkg::*;

    localparam int SW = 4, RD = 4, AW = 12, SWS = 3, RDS = 2, TO = 8;
    localparam int NPIX = SW * RD;
    localparam int INF  = 32'h7fff_ffff;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b1;

    tactile_scanner_if #(.SW_SEL_W(2), .RD_SEL_W(2), .ADC_WIDTH(AW)) bus ();

    tactile_scanner #(
        .SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .ADC_WIDTH(AW),
        .SW_SETTLE_CYCLES(SWS), .RD_SETTLE_CYCLES(RDS), .ADC_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: expected event cycles for the pixel in flight
    int m_req = -1, m_emit = -1, m_valid = -1, m_done = -1, m_adv = -1, m_err_at = -1;
    int m_busy_on = 0, m_busy_off = 0, m_pix = 0, start_cyc = -1, lat;
    bit m_active = 0, m_err = 0, m_err_next = 0, exp_busy, in_conv;
    logic [15:0] m_data;
    logic [AW-1:0] m_vdata;
    bit det_mode = 1, spur_en = 0;
    int to_pix = -1;
    int req_log[$], emit_log[$], done_log[$];
    logic [15:0] data_log[$];

    task automatic clear_logs();
        req_log.delete(); emit_log.delete(); done_log.delete(); data_log.delete();
    endtask

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            check("reset_outputs", 32'(|{bus.sw_sel_out, bus.sw_en_out, bus.rd_sel_out, bus.adc_req_out,
                  bus.data_out, bus.hcount_out, bus.vcount_out, bus.data_valid_out, bus.busy_out,
                  bus.frame_done_out, bus.timeout_err_out}), 0);
            m_req = -1; m_emit = -1; m_valid = -1; m_done = -1; m_adv = -1; m_err_at = -1;
            m_busy_on = 0; m_busy_off = 0; m_pix = 0; m_active = 0; m_err = 0;
            bus.adc_valid_in = 1'b0;
            bus.adc_data_in  = '0;
        end else begin
            if (cyc == m_err_at) m_err = m_err_next;
            exp_busy = (cyc >= m_busy_on) && (cyc < m_busy_off);
            check("busy", bus.busy_out, exp_busy);
            check("sw_en", bus.sw_en_out, exp_busy);
            check("adc_req", bus.adc_req_out, cyc == m_req);
            check("data_valid", bus.data_valid_out, cyc == m_emit);
            check("frame_done", bus.frame_done_out, cyc == m_done);
            check("timeout_err", bus.timeout_err_out, m_err);
            if (cyc == m_req) begin
                check("rd_sel", bus.rd_sel_out, m_pix % RD);
                check("sw_sel", bus.sw_sel_out, m_pix / RD);
            end
            if (cyc == m_emit) begin
                check("data", bus.data_out, m_data);
                check("hcount", bus.hcount_out, m_pix % RD);
                check("vcount", bus.vcount_out, m_pix / RD);
            end

            if (!m_active && cyc >= m_busy_off && bus.start_in) begin
                m_active = 1; start_cyc = cyc; m_busy_on = cyc + 1; m_busy_off = INF;
                m_pix = 0; m_req = cyc + 1 + SWS; m_err_at = cyc + 1; m_err_next = 0;
            end
            if (cyc == m_req) begin
                req_log.push_back(cyc);
                if (m_pix == to_pix) begin
                    m_valid = -1; m_emit = cyc + TO; m_data = 16'hFFFF;
                    m_err_at = m_emit; m_err_next = 1;
                end else begin
                    lat     = det_mode ? 2 : int'($urandom_range(1, 3));
                    m_vdata = det_mode ? AW'(m_pix) : AW'($urandom);
                    m_valid = cyc + lat;
                    m_data  = 16'(m_vdata);
                    m_emit  = m_valid + 1;
                end
            end
            if (cyc == m_emit) begin
                emit_log.push_back(cyc);
                data_log.push_back(bus.data_out);
                m_adv = cyc + 1;
                if (m_pix == NPIX - 1) m_done = cyc + 1;
            end
            if (cyc == m_adv) begin
                if (m_pix == NPIX - 1) begin
                    if (bus.continuous_in) begin
                        m_pix = 0; m_req = cyc + 1 + SWS; m_err_at = cyc + 1; m_err_next = 0;
                    end else begin
                        m_busy_off = cyc + 1; m_active = 0;
                    end
                end else begin
                    m_pix++;
                    m_req = cyc + 1 + (((m_pix % RD) == 0) ? SWS : RDS);
                end
            end
            if (cyc == m_done) done_log.push_back(cyc);

            in_conv = (m_req >= 0) && (cyc >= m_req) && (cyc < m_emit);
            bus.adc_valid_in = 1'b0;
            bus.adc_data_in  = AW'($urandom);
            if (cyc == m_valid) begin
                bus.adc_valid_in = 1'b1;
                bus.adc_data_in  = m_vdata;
            end else if (spur_en && !in_conv && $urandom_range(0, 3) == 0) begin
                bus.adc_valid_in = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk_in); #1 bus.start_in = 1'b1;
        @(posedge clk_in); #1 bus.start_in = 1'b0;
    endtask

    task automatic wait_frame_end();
        int n = 0;
        while ((m_active || bus.busy_out) && n < 3000) begin @(posedge clk_in); n++; end
        check("frame_end_bound", 32'(n < 3000), 1);
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        int n;
        bus.start_in = 1'b0;
        bus.continuous_in = 1'b0;
        #1 rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        @(negedge clk_in);
        check("rst_busy", bus.busy_out, 0);
        check("rst_data", bus.data_out, 0);

        // Basic deterministic frame: latency 2, data = pixel index
        clear_logs();
        pulse_start();
        wait_frame_end();
        check("p1_pix_count", emit_log.size(), 16);
        check("p1_done_count", done_log.size(), 1);
        if (emit_log.size() == 16 && req_log.size() == 16 && done_log.size() == 1) begin
            check("p1_first_req", req_log[0] - start_cyc, 4);
            check("p1_latency", emit_log[0] - req_log[0], 3);
            check("p1_col_gap", req_log[1] - emit_log[0], 4);
            check("p1_row_gap", req_log[4] - emit_log[3], 5);
            check("p1_frame_len", emit_log[15] - start_cyc, 115);
            check("p1_done_after_last", done_log[0] - emit_log[15], 1);
            for (int i = 0; i < 16; i++) check("p1_raster_data", data_log[i], i);
        end
        check("p1_busy_after", bus.busy_out, 0);

        // Timeout on pixel (row 1, col 2), random latency, spurious strobes
        det_mode = 0; spur_en = 1; to_pix = 6;
        clear_logs();
        pulse_start();
        wait_frame_end();
        check("p2_pix_count", emit_log.size(), 16);
        if (emit_log.size() == 16 && req_log.size() == 16) begin
            check("p2_timeout_pixel", data_log[6], 16'hFFFF);
            check("p2_timeout_len", emit_log[6] - req_log[6], 8);
        end
        check("p2_err_sticky", bus.timeout_err_out, 1);

        // Continuous mode with an ignored mid-frame start
        to_pix = -1;
        bus.continuous_in = 1'b1;
        clear_logs();
        pulse_start();
        @(negedge clk_in);
        check("p3_err_cleared", bus.timeout_err_out, 0);
        repeat (30) @(posedge clk_in);
        pulse_start();
        n = 0;
        while (done_log.size() == 0 && n < 3000) begin @(posedge clk_in); n++; end
        check("p3_done_bound", 32'(n < 3000), 1);
        #1 bus.continuous_in = 1'b0;
        wait_frame_end();
        check("p3_pix_count", emit_log.size(), 32);
        check("p3_done_count", done_log.size(), 2);
        if (emit_log.size() == 32 && req_log.size() == 32)
            check("p3_restart_gap", req_log[16] - emit_log[15], 5);

        // Reset during conversion of pixel (row 2, col 1)
        clear_logs();
        pulse_start();
        n = 0;
        do begin
            @(negedge clk_in); n++;
        end while (!(bus.adc_req_out && bus.sw_sel_out == 2'd2 && bus.rd_sel_out == 2'd1) && n < 3000);
        check("p4_reached", 32'(n < 3000), 1);
        @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check("p4_async_sw_en", bus.sw_en_out, 0);
        check("p4_async_busy", bus.busy_out, 0);
        check("p4_async_all", 32'(|{bus.sw_sel_out, bus.rd_sel_out, bus.adc_req_out, bus.data_out,
              bus.hcount_out, bus.vcount_out, bus.data_valid_out, bus.frame_done_out,
              bus.timeout_err_out}), 0);
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        clear_logs();
        pulse_start();
        wait_frame_end();
        check("p4_pix_count", emit_log.size(), 16);
        check("p4_done_count", done_log.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tactile_scanner.md
Name: tactile_scanner

Overview:
- Upstream of the 3-row line buffer. Walks the tactile array one drive (switch) wire at a time and one sense (read) wire at a time.
- For each crossing it waits a settle time, runs one ADC conversion, and emits one pixel stamped with hcount (read wire) and vcount (switch wire).
- Output stream matches the line buffer's input contract: data, hcount, vcount, data_valid.

Parameters:
- SW_WIRE_CNT, 16, number of drive wires (rows); vcount range 0..SW_WIRE_CNT-1.
- RD_WIRE_CNT, 16, number of sense wires (columns); hcount range 0..RD_WIRE_CNT-1.
- ADC_WIDTH, 12, ADC result width; must be ≤16.
- SW_SETTLE_CYCLES, 200, wait after a drive-wire change; must be ≥1.
- RD_SETTLE_CYCLES, 20, wait after a sense-mux change; must be ≥1.
- ADC_TIMEOUT_CYCLES, 1024, maximum wait for adc_valid_in.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous reset, active-low; one clock domain only
- start_in  in  1  pulse; begins one frame when idle
- continuous_in  in  1  when high at frame end, the next frame starts automatically
- adc_data_in  in  ADC_WIDTH  conversion result
- adc_valid_in  in  1  one-cycle strobe; adc_data_in is valid on this cycle
- sw_sel_out  out  $clog2(SW_WIRE_CNT)  drive-wire mux select
- sw_en_out  out  1  drive enable
- rd_sel_out  out  $clog2(RD_WIRE_CNT)  sense-wire mux select
- adc_req_out  out  1  one-cycle conversion request
- data_out  out  16  pixel, zero-extended ADC result
- hcount_out  out  11  read index, zero-extended
- vcount_out  out  10  switch index, zero-extended
- data_valid_out  out  1  one-cycle pixel strobe
- busy_out  out  1  high from frame start until frame end
- frame_done_out  out  1  one-cycle pulse after the last pixel
- timeout_err_out  out  1  sticky; cleared at next frame start

Behaviour:
- Reset (async assert, sync deassert): every output is 0; state IDLE; counters 0. sw_en_out drops immediately, including when reset hits mid-frame.
- States: IDLE, SETTLE, CONVERT, EMIT, ADVANCE.
- IDLE:
  - start_in=1 → sw_sel=0, rd_sel=0, sw_en=1, busy=1, timeout_err cleared, settle counter loaded with SW_SETTLE_CYCLES → SETTLE.
  - start_in while busy is ignored.
- SETTLE: counter decrements each cycle. On the cycle it reads 1 → assert adc_req_out for exactly that next cycle → CONVERT.
- CONVERT:
  - Timeout counter runs from the adc_req cycle.
  - adc_valid_in=1 → capture {zero pad, adc_data_in} → EMIT.
  - Counter reaches ADC_TIMEOUT_CYCLES → capture 16'hFFFF, set timeout_err → EMIT.
  - adc_valid_in outside CONVERT is ignored, including on the adc_req cycle if it precedes the request.
- EMIT:
  - data_valid_out=1 for exactly one cycle, with data_out, hcount_out=rd_sel, vcount_out=sw_sel held in the same cycle.
  - Latency: adc_valid_in at cycle N → data_valid_out at N+1.
  - data/hcount/vcount outputs hold their values until the next EMIT.
- ADVANCE:
  - rd_sel<RD_WIRE_CNT-1 → rd_sel+1, load RD_SETTLE_CYCLES → SETTLE.
  - Else rd_sel=0. If sw_sel<SW_WIRE_CNT-1 → sw_sel+1, load SW_SETTLE_CYCLES → SETTLE.
  - Else (last pixel) frame_done_out pulses one cycle. continuous_in=1 → restart at (0,0) with SW settle, busy stays high. Otherwise sw_en=0, busy=0 → IDLE.
- Ordering: raster order, hcount fastest; one pixel per settle+convert period. data_valid_out is never high on consecutive cycles.
- Per-pixel minimum cycles: settle + 1 (req) + ADC latency + 1 (EMIT) + 1 (ADVANCE).
- Wrap: hcount wraps to 0 and vcount increments on the same pixel boundary. No pixel is skipped or duplicated.

Decomposition:
- tactile_pkg holds:
  - scan_state_t enum (IDLE, SETTLE, CONVERT, EMIT, ADVANCE)
  - HCOUNT_W=11, VCOUNT_W=10, PIX_W=16
  - TIMEOUT_PIXEL=16'hFFFF
- Sub-module settle_timer: loadable down-counter with load_in, value_in, expire_out. Reused for both the settle counter and the ADC timeout counter.

Test Plan:
- Basic frame: SW=RD=4, settle 3/2, ADC model returns (4*row+col) 2 cycles after adc_req → exactly 16 data_valid pulses in raster order with data=0..15 matching hcount/vcount; frame_done one cycle after the 16th; busy then 0.
- Latency/handshake: single pixel; adc_valid at cycle N → data_valid at N+1. adc_req is one cycle wide and occurs exactly SETTLE_CYCLES after the select change. A spurious adc_valid during SETTLE is ignored.
- Timeout: ADC never responds on pixel (1,2), ADC_TIMEOUT=8 → that pixel data=16'hFFFF, timeout_err=1 sticky, remaining pixels normal; err clears on next start_in.
- Continuous + ignored start: continuous_in=1, start_in pulsed mid-frame → no disruption; second frame begins immediately after frame_done with hcount=vcount=0.
- Reset mid-frame: rst_n_in low during CONVERT of pixel (2,1) → all outputs 0 asynchronously; after release, start_in gives a clean frame from (0,0).
- Full 16x16 into the line buffer: pixel data={vcount,hcount} → 256 pixels, last hcount=15 vcount=15; the line buffer output matches its golden check.
